mult_booth_ctrl: RTL

- Control FSM for the radix-2 Booth multiplier datapath.
- Each cycle it consumes the datapath's 2-bit Booth pair Q_LSB = {Q0, Q_1} and produces the mult_control_t word (load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub).
- It sequences one N-iteration multiply per start request and exposes a busy/done handshake to the upstream requester.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_booth_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/mult_pkg.sv
// Shared types for the radix-2 Booth multiplier: datapath control word, controller states, Booth pair codes.
package mult_pkg;

    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_booth_ctrl.sv
// Booth multiplier controller: N iterations per start, done after N+K+1 edges; start ignored while busy.
// MULT_BOOTH_CTRL_DONE_HOLD_EN adds done_ack and holds DONE until it is sampled high.
module mult_booth_ctrl
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    Q_LSB,
`ifdef MULT_BOOTH_CTRL_DONE_HOLD_EN
    input  logic          done_ack,
`endif
    output mult_control_t mult_control,
    output logic          busy,
    output logic          done
);

    localparam int CNT_W = $clog2(N + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             booth_op;
    logic             last_iter;

    assign booth_op  = (Q_LSB == BOOTH_ADD) || (Q_LSB == BOOTH_SUB);
    assign last_iter = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_LOAD;
                S_LOAD: begin
                    cnt   <= CNT_W'(N);
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    // A non-zero Booth pair spends an extra cycle in SHIFT before the shift.
                    if (booth_op) begin
                        state <= S_SHIFT;
                    end else begin
                        cnt   <= cnt - CNT_W'(1);
                        state <= last_iter ? S_DONE : S_EVAL;
                    end
                end
                S_SHIFT: begin
                    cnt   <= cnt - CNT_W'(1);
                    state <= last_iter ? S_DONE : S_EVAL;
                end
                S_DONE: begin
`ifdef MULT_BOOTH_CTRL_DONE_HOLD_EN
                    if (done_ack) state <= S_IDLE;
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mult_control = '0;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        case (state)
            S_LOAD: begin
                mult_control.load_A = 1'b1;
                mult_control.load_B = 1'b1;
            end
            S_EVAL: begin
                if (Q_LSB == BOOTH_SUB) begin
                    mult_control.load_add = 1'b1;
                end else if (Q_LSB == BOOTH_ADD) begin
                    mult_control.load_add = 1'b1;
                    mult_control.add_sub  = 1'b1;
                end else begin
                    mult_control.shift_HQ_LQ_Q_1 = 1'b1;
                end
            end
            S_SHIFT: mult_control.shift_HQ_LQ_Q_1 = 1'b1;
            default: ;
        endcase
    end

endmodule
